// File: rtl/rat_pipeline_pkg.sv
// Shared constants, PC load-source encoding and small helpers for the RAT pipeline front end.
package rat_pipeline_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 18;

    localparam logic [PC_W-1:0]    INT_VECTOR = 10'h3FF;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 18'h00000;
    localparam logic [INSTR_W-1:0] INT_INSTR  = 18'h3C000;

    typedef enum logic [2:0] {
        SEL_IMM     = 3'd0,
        SEL_STACK   = 3'd1,
        SEL_INT     = 3'd2,
        SEL_MISS    = 3'd3,
        SEL_PREDICT = 3'd4
    } PcSel;

    function automatic logic sel_is_legal(input logic [2:0] sel);
        return (sel <= 3'd4);
    endfunction

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/fetch_stage_fetch_latch.sv
// Fetch-to-decode pipeline register: holds {instr, pc, valid}; stall holds, clear squashes.
module fetch_latch #(
    parameter int PC_W    = rat_pipeline_pkg::PC_W,
    parameter int INSTR_W = rat_pipeline_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               clear,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               valid
);
    import rat_pipeline_pkg::*;

    // Stall has priority over clear so a held slot is never lost to a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc    <= {PC_W{1'b0}};
            valid <= 1'b0;
        end else if (stall) begin
            instr <= instr;
            pc    <= pc;
            valid <= valid;
        end else if (clear) begin
            instr <= NOP_INSTR;
            pc    <= {PC_W{1'b0}};
            valid <= 1'b0;
        end else begin
            instr <= in_instr;
            pc    <= in_pc;
            valid <= in_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing, instruction-memory addressing, decode-slot overrides and
// stall/flush performance counters.
module fetch_stage #(
    parameter int PC_W    = rat_pipeline_pkg::PC_W,
    parameter int INSTR_W = rat_pipeline_pkg::INSTR_W,
    parameter logic [PC_W-1:0] INT_VECTOR = rat_pipeline_pkg::INT_VECTOR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_inc,
    input  logic               pc_load,
    input  logic               pc_reset,
    input  logic [2:0]         pc_mux_sel,
    input  logic [PC_W-1:0]    branch_imm,
    input  logic [PC_W-1:0]    stack_addr,
    input  logic [PC_W-1:0]    miss_addr,
    input  logic [PC_W-1:0]    predict_target,
    input  logic               imem_addr_mux,
    input  logic               fetch_latch_stall,
    input  logic               dec_nop,
    input  logic               dec_int,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic               dec_valid,
    output logic               dec_is_int,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
);
    import rat_pipeline_pkg::*;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_next_s;
    logic [PC_W-1:0]    load_addr_s;
    logic [PC_W-1:0]    imem_addr_s;
    logic [PC_W-1:0]    issued_q;
    logic               fetch_valid_q;
    logic               sel_err;
    logic               sel_legal_s;
    logic               load_ok_s;
    logic               sel_bad_s;
    logic               flush_evt_s;
    logic [15:0]        stall_cnt_r;
    logic [15:0]        flush_cnt_r;
    logic [INSTR_W-1:0] lat_instr_s;
    logic [PC_W-1:0]    lat_pc_s;
    logic               lat_valid_s;

    assign sel_legal_s = sel_is_legal(pc_mux_sel);
    assign load_ok_s   = pc_load & sel_legal_s;
    assign sel_bad_s   = pc_load & ~sel_legal_s;
    assign flush_evt_s = dec_nop & ~dec_int;

    // Load-source mux; illegal selects fall back to the current PC so a bad load holds.
    always_comb begin
        load_addr_s = pc_r;
        case (pc_mux_sel)
            SEL_IMM:     load_addr_s = branch_imm;
            SEL_STACK:   load_addr_s = stack_addr;
            SEL_INT:     load_addr_s = INT_VECTOR;
            SEL_MISS:    load_addr_s = miss_addr;
            SEL_PREDICT: load_addr_s = predict_target;
            default:     load_addr_s = pc_r;
        endcase
    end

    // Next-PC priority: clear, then load, then increment (natural wrap at the top), else hold.
    always_comb begin
        pc_next_s = pc_r;
        if (pc_reset) begin
            pc_next_s = {PC_W{1'b0}};
        end else if (pc_load) begin
            pc_next_s = load_addr_s;
        end else if (pc_inc) begin
            pc_next_s = pc_r + PC_ONE;
        end else begin
            pc_next_s = pc_r;
        end
    end

    assign imem_addr_s = imem_addr_mux ? issued_q : pc_r;
    assign imem_addr   = imem_addr_s;
    assign pc          = pc_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

    // issued_q mirrors the address the memory saw last cycle, so it pairs with imem_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= {PC_W{1'b0}};
            issued_q      <= {PC_W{1'b0}};
            fetch_valid_q <= 1'b0;
            sel_err       <= 1'b0;
            stall_cnt_r   <= 16'h0000;
            flush_cnt_r   <= 16'h0000;
        end else begin
            pc_r          <= pc_next_s;
            issued_q      <= imem_addr_s;
            fetch_valid_q <= 1'b1;
            sel_err       <= sel_err | sel_bad_s;
            stall_cnt_r   <= fetch_latch_stall ? sat_inc16(stall_cnt_r) : stall_cnt_r;
            flush_cnt_r   <= flush_evt_s ? sat_inc16(flush_cnt_r) : flush_cnt_r;
        end
    end

    fetch_latch #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fetch_latch (
        .clk      (clk),
        .reset    (reset),
        .stall    (fetch_latch_stall),
        .clear    (load_ok_s),
        .in_instr (imem_data),
        .in_pc    (issued_q),
        .in_valid (fetch_valid_q),
        .instr    (lat_instr_s),
        .pc       (lat_pc_s),
        .valid    (lat_valid_s)
    );

    // Decode-slot overrides; an injected interrupt carries the latched PC as its return address.
    always_comb begin
        dec_instr  = lat_instr_s;
        dec_pc     = lat_pc_s;
        dec_valid  = lat_valid_s;
        dec_is_int = 1'b0;
        if (dec_int) begin
            dec_instr  = INT_INSTR;
            dec_valid  = 1'b1;
            dec_is_int = 1'b1;
        end else if (dec_nop) begin
            dec_instr  = NOP_INSTR;
            dec_valid  = 1'b0;
        end else begin
            dec_instr  = lat_instr_s;
            dec_valid  = lat_valid_s;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters: PC_W=10, program counter width; INSTR_W=18, instruction width; INT_VECTOR=10'h3FF, interrupt handler address.
REQ-002 Signals, in order: name  direction  width  meaning. clk input 1, clock; reset input 1, synchronous, active-high.
REQ-003 pc_inc / pc_load / pc_reset input 1 each: PC increment, load and clear commands from the hazard controller.
REQ-004 pc_mux_sel input 3: load source; 0=branch_imm, 1=stack_addr, 2=INT_VECTOR, 3=miss_addr, 4=predict_target.
REQ-005 branch_imm / stack_addr / miss_addr / predict_target input PC_W each: candidate load addresses.
REQ-006 imem_addr_mux input 1: 1 = re-issue previous fetch address. fetch_latch_stall input 1: hold decode latch.
REQ-007 dec_nop input 1: squash the decode slot. dec_int input 1: inject an interrupt into the decode slot.
REQ-008 imem_addr output PC_W: address to synchronous instruction memory (1-cycle read latency). imem_data input INSTR_W: read data.
REQ-009 pc output PC_W: current PC. dec_instr output INSTR_W, dec_pc output PC_W, dec_valid output 1, dec_is_int output 1: decode-slot contents.
REQ-010 stall_cnt / flush_cnt output 16 each: performance counters.

Function
REQ-011 PC update priority per clk edge: reset or pc_reset -> 0; else pc_load -> source selected by pc_mux_sel; else pc_inc -> pc+1, wrapping 10'h3FF->10'h000; else hold.
REQ-012 pc_mux_sel values 5-7 with pc_load=1 hold the PC and set sticky sel_err (internal, visible to the bench); sel_err clears only on reset.
REQ-013 imem_addr = imem_addr_mux ? issued_q : pc, combinational; issued_q registers imem_addr every cycle.
REQ-014 The fetch latch captures {imem_data, issued_q, fetch_valid_q} each cycle unless fetch_latch_stall=1, in which case it holds.
REQ-015 fetch_valid_q is 0 for the first cycle after reset and 1 thereafter; latch valid is 0 until the first post-reset instruction is captured.
REQ-016 The latch is cleared to NOP_INSTR, valid=0 on the clk edge after any pc_load=1 with a legal sel and fetch_latch_stall=0 (wrong-path word discarded); stall=1 takes priority and holds.
REQ-017 Decode outputs are combinational overrides of the latch: dec_int=1 -> dec_instr=INT_INSTR, dec_is_int=1, dec_valid=1, dec_pc=latch pc (return address); else dec_nop=1 -> dec_instr=NOP_INSTR, dec_valid=0; else latch contents.
REQ-018 dec_int and dec_nop both 1 -> dec_int wins. dec_int is a single-cycle pulse; no internal extension.
REQ-019 stall_cnt +1 on each cycle with fetch_latch_stall=1; flush_cnt +1 on each cycle with dec_nop=1 and dec_int=0; both saturate at 16'hFFFF.
REQ-020 Steady state latency: address issued at cycle n appears on dec_instr at cycle n+2.

Reset
REQ-021 reset=1: pc=0, issued_q=0, latch={NOP_INSTR, 0, valid=0}, fetch_valid_q=0, counters=0, sel_err=0 on the next edge; reset overrides every other input.
REQ-022 reset=1 mid-stall or mid-load discards pending state; the first fetch after release is address 0.

Structure
REQ-023 Package rat_pipeline_pkg holds PC_W, INSTR_W, INT_VECTOR, NOP_INSTR (18'h0), INT_INSTR, and the PcSel enum (SEL_IMM, SEL_STACK, SEL_INT, SEL_MISS, SEL_PREDICT); the hazard controller imports the same enum.
REQ-024 One sub-module, fetch_latch: holds {instr, pc, valid} with stall and clear inputs; counters and PC logic stay in fetch_stage.

Verification
REQ-025 Reset release with pc_inc=1 and memory word[i]=i -> imem_addr 0,1,2,...; dec_instr=0 with dec_valid=1 at cycle 2; dec_valid=0 before that.
REQ-026 pc=10'h3FF, pc_inc=1 -> pc=10'h000 on the next edge with no other side effects.
REQ-027 pc=5, 2-cycle imem_addr_mux=1 with fetch_latch_stall=1 -> imem_addr=issued_q for both cycles; dec_instr held; stall_cnt +2; stream resumes at 6 without loss or duplication.
REQ-028 pc_load=1, sel=3, miss_addr=10'h040 -> pc=10'h040; next dec_valid=0 (flushed); word 0x040 reaches decode 2 cycles later.
REQ-029 dec_int=1 and dec_nop=1 with latch pc=10'h012 -> dec_instr=INT_INSTR, dec_is_int=1, dec_pc=10'h012, flush_cnt unchanged; then pc_load sel=2 -> pc=10'h3FF.
REQ-030 pc_load=1 with sel=6 -> pc holds and sel_err=1; reset asserted during a stall -> all outputs at REQ-021 values one edge later.
